sel_mux_pipe: RTL and testbench
===============================

Name: sel_mux_pipe

Overview:
- Parametrised N:1 operand/register-address selector with a registered output stage and a 2-entry skid buffer.
- Successor to the fixed 5-bit 2:1 combinational select muxes used between pipeline stages.
- Sits between decode/issue stages wherever a selected field must cross a stage boundary under valid/ready back-pressure.
- Adds flush and out-of-range select detection.

Parameters:
- WIDTH, 5: data width of each input and of the output.
- NUM_IN, 2: number of selectable inputs (>=2).
- SEL_W, 1: select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to forward.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat.
- flush  input  1  discard all buffered beats.
- out_data  output  WIDTH  selected data, registered.
- out_sel_err  output  1  beat was captured with in_sel >= NUM_IN.
- out_valid  output  1  out_data/out_sel_err valid.
- out_ready  input  1  downstream accepts the beat.
- err_sticky  output  1  an out-of-range select has been accepted since reset or the last clear.
- err_clr  input  1  clears err_sticky.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Selection:
  - Selected value = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN.
  - Otherwise the selected value is all-zero, with the error bit = 1; the beat still propagates.
- Storage:
  - Output register (data, err, valid) plus skid register (data, err, skid_valid).
  - in_ready = !skid_valid && !rst. It depends only on registered state; no combinational path from out_ready.
- Per-edge update (flush = 0):
  - If !out_valid || out_ready:
    - Skid valid: output register loads skid; skid_valid <= 0.
    - Else, input transfer: output register loads the selected input.
    - Else: out_valid <= 0.
  - If out_valid && !out_ready and an input transfer occurs: skid loads the selected input; skid_valid <= 1.
  - Output register holds its value while out_valid && !out_ready.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid when unstalled.
  - Sustains 1 beat/cycle.
  - No beat is lost or duplicated under any out_ready pattern.
  - Order is preserved.
- flush (priority over all but rst):
  - Next edge: out_valid <= 0, skid_valid <= 0.
  - A beat presented in the same cycle is dropped and does not touch err_sticky.
  - in_ready = 1 on the following cycle.
- err_sticky:
  - Set on any input transfer with in_sel >= NUM_IN (flush = 0).
  - Cleared by err_clr; set wins if both occur in the same cycle.
- Reset:
  - While rst is high, in_ready = 0.
  - At the edge: out_valid = 0, skid_valid = 0, out_data = 0, out_sel_err = 0, err_sticky = 0.
  - First cycle after reset: in_ready = 1.
  - Reset mid-stream discards both buffered beats.
- out_data and out_sel_err change only on an edge that loads the output register.

Test Plan:
- Reset, WIDTH=5, NUM_IN=2: in_data={5'd9,5'd3}, sel=1, valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=9; following cycle out_valid=0.
- NUM_IN=4, WIDTH=8, streaming sel=0,1,2,3 on consecutive cycles with out_ready=1 -> outputs appear in order, one per cycle, 1-cycle latency, in_ready stays 1.
- Same stream with out_ready=0 from the second output -> first beat held stable, second beat in skid, in_ready=0; raise out_ready -> all four beats delivered in order, none lost.
- NUM_IN=3, SEL_W=2, sel=3 accepted -> out_data=0, out_sel_err=1, err_sticky=1; err_clr alone -> err_sticky=0; err_clr together with another sel=3 transfer -> err_sticky stays 1.
- Both registers full (out_ready=0), assert flush with in_valid=1 -> next cycle out_valid=0, skid empty, in_ready=1, err_sticky unchanged, dropped beat never appears.
- rst asserted while both registers are full -> in_ready=0 during rst; afterwards all outputs 0 and in_ready=1; no stale beat emerges.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: N:1 field selector with registered output, skid buffer, flush and out-of-range select detection
module sel_mux_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_sticky,
  input  logic                    err_clr
);
  localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];
  logic [WIDTH-1:0] ins [2**SEL_W];
  logic [WIDTH-1:0] sel_data, out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic sel_err, in_fire, load_out;
  logic out_err_q, out_err_d, out_valid_q, out_valid_d;
  logic skid_err_q, skid_err_d, skid_valid_q, skid_valid_d;
  logic err_sticky_q, err_sticky_d;
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_in
    if (k < NUM_IN) begin : g_real
      assign ins[k] = in_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ins[k] = '0;
    end
  end
  assign sel_err  = !({1'b0, in_sel} < NUM_IN_W);
  assign sel_data = ins[in_sel];
  assign in_ready = !skid_valid_q && !rst;
  assign in_fire  = in_valid && in_ready;
  assign load_out = !out_valid_q || out_ready;
  always_comb begin
    out_valid_d  = flush ? 1'b0 : load_out ? (skid_valid_q || in_fire) : out_valid_q;
    out_data_d   = (flush || !load_out) ? out_data_q : skid_valid_q ? skid_data_q : in_fire ? sel_data : out_data_q;
    out_err_d    = (flush || !load_out) ? out_err_q : skid_valid_q ? skid_err_q : in_fire ? sel_err : out_err_q;
    skid_valid_d = (flush || load_out) ? 1'b0 : in_fire ? 1'b1 : skid_valid_q;
    skid_data_d  = (!flush && !load_out && in_fire) ? sel_data : skid_data_q;
    skid_err_d   = (!flush && !load_out && in_fire) ? sel_err : skid_err_q;
    err_sticky_d = (!flush && in_fire && sel_err) || (err_sticky_q && !err_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      err_sticky_q <= err_sticky_d;
    end
  end
  assign out_data    = out_data_q;
  assign out_sel_err = out_err_q;
  assign out_valid   = out_valid_q;
  assign err_sticky  = err_sticky_q;
endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe: directed self-checking bench for sel_mux_pipe in three configurations
module tb_sel_mux_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  logic [9:0] a_data;
  logic [0:0] a_sel;
  logic a_valid, a_ready, a_flush, a_err, a_ov, a_or, a_stk, a_clr;
  logic [4:0] a_out;
  logic [31:0] b_data;
  logic [1:0] b_sel;
  logic b_valid, b_ready, b_flush, b_err, b_ov, b_or, b_stk, b_clr;
  logic [7:0] b_out;
  logic [23:0] c_data;
  logic [1:0] c_sel;
  logic c_valid, c_ready, c_flush, c_err, c_ov, c_or, c_stk, c_clr;
  logic [7:0] c_out;
  sel_mux_pipe #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
    .in_ready(a_ready), .flush(a_flush), .out_data(a_out), .out_sel_err(a_err),
    .out_valid(a_ov), .out_ready(a_or), .err_sticky(a_stk), .err_clr(a_clr)
  );
  sel_mux_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_ready), .flush(b_flush), .out_data(b_out), .out_sel_err(b_err),
    .out_valid(b_ov), .out_ready(b_or), .err_sticky(b_stk), .err_clr(b_clr)
  );
  sel_mux_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
    .in_ready(c_ready), .flush(c_flush), .out_data(c_out), .out_sel_err(c_err),
    .out_valid(c_ov), .out_ready(c_or), .err_sticky(c_stk), .err_clr(c_clr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    a_data = '0; a_sel = '0; a_valid = 0; a_flush = 0; a_or = 0; a_clr = 0;
    b_data = '0; b_sel = '0; b_valid = 0; b_flush = 0; b_or = 0; b_clr = 0;
    c_data = '0; c_sel = '0; c_valid = 0; c_flush = 0; c_or = 0; c_clr = 0;
    repeat (2) tick();
    chk("rst_ready", a_ready, 0);
    chk("rst_ov", a_ov, 0);
    chk("rst_out", a_out, 0);
    chk("rst_stk", a_stk, 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", a_ready, 1);
    a_data = {5'd9, 5'd3}; a_sel = 1'b1; a_valid = 1; a_or = 1;
    tick();
    chk("a_ov1", a_ov, 1);
    chk("a_out9", a_out, 9);
    chk("a_err0", a_err, 0);
    a_valid = 0;
    tick();
    chk("a_ov0", a_ov, 0);
    chk("a_out_hold", a_out, 9);
    b_data = {8'h44, 8'h33, 8'h22, 8'h11}; b_or = 1;
    for (int i = 0; i < 4; i++) begin
      b_sel = 2'(i); b_valid = 1;
      #1 chk("b_stream_ready", b_ready, 1);
      tick();
      chk("b_stream_ov", b_ov, 1);
      chk("b_stream_out", b_out, 32'(8'h11 * (i + 1)));
    end
    b_valid = 0;
    tick();
    chk("b_stream_end", b_ov, 0);
    b_sel = 2'd0; b_valid = 1; b_or = 1;
    tick();
    chk("b_st_out0", b_out, 8'h11);
    b_or = 0; b_sel = 2'd1;
    tick();
    chk("b_st_hold1", b_out, 8'h11);
    chk("b_st_ov", b_ov, 1);
    chk("b_st_ready0", b_ready, 0);
    b_sel = 2'd2;
    tick();
    chk("b_st_hold2", b_out, 8'h11);
    chk("b_st_ready0b", b_ready, 0);
    b_or = 1;
    tick();
    chk("b_st_out1", b_out, 8'h22);
    chk("b_st_ready1", b_ready, 1);
    tick();
    chk("b_st_out2", b_out, 8'h33);
    b_sel = 2'd3;
    tick();
    chk("b_st_out3", b_out, 8'h44);
    b_valid = 0;
    tick();
    chk("b_st_end", b_ov, 0);
    c_data = {8'hCC, 8'hBB, 8'hAA}; c_or = 1; c_sel = 2'd2; c_valid = 1;
    tick();
    chk("c_out2", c_out, 8'hCC);
    chk("c_err2", c_err, 0);
    chk("c_stk_clean", c_stk, 0);
    c_sel = 2'd3;
    tick();
    chk("c_bad_out", c_out, 0);
    chk("c_bad_err", c_err, 1);
    chk("c_bad_ov", c_ov, 1);
    chk("c_bad_stk", c_stk, 1);
    c_valid = 0; c_clr = 1;
    tick();
    chk("c_clr_stk", c_stk, 0);
    c_valid = 1; c_sel = 2'd3;
    tick();
    chk("c_clr_set_stk", c_stk, 1);
    c_valid = 0;
    tick();
    c_clr = 0;
    chk("c_stk_cleared", c_stk, 0);
    c_or = 0; c_sel = 2'd0; c_valid = 1;
    tick();
    c_sel = 2'd1;
    tick();
    chk("c_full_ready", c_ready, 0);
    chk("c_full_out", c_out, 8'hAA);
    c_flush = 1; c_sel = 2'd3;
    tick();
    chk("c_fl_ov", c_ov, 0);
    chk("c_fl_ready", c_ready, 1);
    chk("c_fl_stk", c_stk, 0);
    tick();
    chk("c_fl2_ov", c_ov, 0);
    chk("c_fl2_stk", c_stk, 0);
    c_flush = 0; c_valid = 0; c_or = 1;
    tick();
    chk("c_fl_none", c_ov, 0);
    tick();
    chk("c_fl_none2", c_ov, 0);
    a_or = 0; a_sel = 1'b0; a_valid = 1;
    tick();
    a_sel = 1'b1;
    tick();
    chk("a_full_ready", a_ready, 0);
    chk("a_full_out", a_out, 3);
    rst = 1'b1;
    #1 chk("a_rst_ready", a_ready, 0);
    tick();
    chk("a_rst_ready_hi", a_ready, 0);
    chk("a_rst_ov", a_ov, 0);
    rst = 1'b0; a_valid = 0; a_or = 1;
    #1 chk("a_rst_ready1", a_ready, 1);
    chk("a_rst_out", a_out, 0);
    chk("a_rst_err", a_err, 0);
    chk("a_rst_stk", a_stk, 0);
    tick();
    chk("a_rst_nostale", a_ov, 0);
    tick();
    chk("a_rst_nostale2", a_ov, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
